// File: rtl/bsg_down_ch_sched_if.sv
// Bundle between the downstream channel FIFO read ports and the core-side output register.
// Latency: none (wires only).
// Backpressure: the core stalls the held word by withholding core_yumi_i; channels are dequeued only via ch_yumi_o.
//
// Signals:
//   ch_valid_i   NUM_CH     channel i FIFO non-empty
//   ch_data_i    NUM_CH*DW  channel i head word at [i*DW +: DW]
//   ch_yumi_o    NUM_CH     one-hot dequeue pulse back to the channel FIFOs
//   core_valid_o 1          output register holds a word
//   core_data_o  DW         held word
//   core_ch_o    CW         source channel of the held word
//   core_yumi_i  1          core consumes the held word this cycle
// Modports: master = scheduler side, slave = FIFOs/core side.
interface bsg_down_ch_sched_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 16
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]    ch_valid_i;
  logic [NUM_CH*DW-1:0] ch_data_i;
  logic [NUM_CH-1:0]    ch_yumi_o;
  logic                 core_valid_o;
  logic [DW-1:0]        core_data_o;
  logic [CW-1:0]        core_ch_o;
  logic                 core_yumi_i;

  modport master (
    input  ch_valid_i,
    input  ch_data_i,
    input  core_yumi_i,
    output ch_yumi_o,
    output core_valid_o,
    output core_data_o,
    output core_ch_o
  );

  modport slave (
    output ch_valid_i,
    output ch_data_i,
    output core_yumi_i,
    input  ch_yumi_o,
    input  core_valid_o,
    input  core_data_o,
    input  core_ch_o
  );
endinterface

// File: rtl/bsg_down_ch_sched.sv
// Round-robin drain of NUM_CH downstream channel FIFOs into one registered core-side word.
// Latency: ch_yumi_o combinational in the grant cycle, word visible on core_valid_o one cycle later.
// Backpressure: a held word without core_yumi_i blocks all grants; yumi+grant passes through at 1 word/cycle.
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   enable_i     permits new grants
//   ch_mask_i    bit i high removes channel i from arbitration
//   bus          channel/core handshake bundle (master modport)
//   token_o      one-cycle credit pulse per channel, every TOK_DEC dequeues
//   busy_o       held word present or any unmasked channel non-empty
// The interface instance must be built with the same NUM_CH/DW as this module.
module bsg_down_ch_sched #(
  parameter int NUM_CH  = 4,
  parameter int DW      = 16,
  parameter int TOK_DEC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [NUM_CH-1:0]   ch_mask_i,
  bsg_down_ch_sched_if.master bus,
  output logic [NUM_CH-1:0]   token_o,
  output logic                busy_o
);

  localparam int CW = $clog2(NUM_CH);
  localparam int TW = $clog2(TOK_DEC);

  // Arbitration state and results
  logic [CW-1:0]           rr_ptr;
  logic [NUM_CH-1:0]       eligible;
  logic                    found;
  logic [CW-1:0]           gnt_idx;
  logic [CW-1:0]           gnt_idx_inc;
  logic                    slot_free;
  logic                    grant;
  logic [NUM_CH-1:0]       yumi;
  logic [DW-1:0]           gnt_data;

  // Output register
  logic                    core_valid_q;
  logic [DW-1:0]           core_data_q;
  logic [CW-1:0]           core_ch_q;

  // Credit return
  logic [NUM_CH-1:0][TW-1:0] tok_cnt;
  logic [NUM_CH-1:0]         token_q;

  assign eligible = bus.ch_valid_i & ~ch_mask_i;

  // First eligible channel at or after rr_ptr, wrapping. The modulo keeps
  // the scan correct for channel counts that are not a power of two.
  always_comb begin
    logic [CW-1:0] cand;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = CW'((int'(rr_ptr) + off) % NUM_CH);
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // The slot is also free when the core drains the held word this very
  // cycle, which is what allows back-to-back words at full rate.
  assign slot_free = !core_valid_q || bus.core_yumi_i;

  // Grants are suppressed during reset so no FIFO is popped while the
  // output register is being cleared.
  assign grant = slot_free && enable_i && found && !rst;

  always_comb begin
    yumi = '0;
    if (grant) begin
      yumi[gnt_idx] = 1'b1;
    end
  end

  assign bus.ch_yumi_o = yumi;

  // Head-word mux for the granted channel
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CW'(i)) begin
        gnt_data = bus.ch_data_i[i*DW +: DW];
      end
    end
  end

  assign gnt_idx_inc = (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
      core_ch_q    <= '0;
      rr_ptr       <= '0;
    end else begin
      if (grant) begin
        core_valid_q <= 1'b1;
        core_data_q  <= gnt_data;
        core_ch_q    <= gnt_idx;
        rr_ptr       <= gnt_idx_inc;
      end else if (core_valid_q && bus.core_yumi_i) begin
        // Drained with nothing to replace it; data/channel keep their
        // last values but are qualified off by core_valid.
        core_valid_q <= 1'b0;
      end
    end
  end

  // Per-channel dequeue counters. TOK_DEC is a power of two, so the natural
  // wrap of a TW-bit counter returns it to zero after TOK_DEC-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_cnt <= '0;
      token_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        token_q[i] <= yumi[i] && (tok_cnt[i] == TW'(TOK_DEC - 1));
        if (yumi[i]) begin
          tok_cnt[i] <= tok_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.core_valid_o = core_valid_q;
  assign bus.core_data_o  = core_data_q;
  assign bus.core_ch_o    = core_ch_q;
  assign token_o          = token_q;
  assign busy_o           = core_valid_q || (|eligible);

  // Dequeue pulses are at most one-hot and only for channels that can be granted
  ap_yumi_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(yumi));
  ap_yumi_eligible : assert property (@(posedge clk) disable iff (rst)
    (yumi & ~eligible) == '0);
  // A stalled word stays put
  ap_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (core_valid_q && !bus.core_yumi_i) |=>
      (core_valid_q && $stable(core_data_q) && $stable(core_ch_q)));

endmodule

// File: tb/tb_bsg_down_ch_sched.sv
module tb_bsg_down_ch_sched;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] data;
  } exp_t;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       enable  = 1'b0;
  logic [3:0] ch_mask = 4'b0000;
  logic [3:0] token;
  logic       busy;

  bsg_down_ch_sched_if #(.NUM_CH(4), .DW(16)) bus ();

  bsg_down_ch_sched #(.NUM_CH(4), .DW(16), .TOK_DEC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (enable),
    .ch_mask_i (ch_mask),
    .bus       (bus),
    .token_o   (token),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard of words the core should receive, in order
  exp_t sb[$];

  // Channel FIFO models
  logic [15:0] mem [4][64];
  int          wr [4] = '{0, 0, 0, 0};
  int          rd [4] = '{0, 0, 0, 0};
  logic        flush = 1'b0;

  int         acc_cnt = 0;
  int         tok_cnt [4] = '{0, 0, 0, 0};
  int         dq_cnt  [4] = '{0, 0, 0, 0};
  logic [3:0] exp_tok = 4'b0000;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always_comb begin
    bus.ch_valid_i = '0;
    bus.ch_data_i  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.ch_valid_i[i]          = (rd[i] != wr[i]);
      bus.ch_data_i[i*16 +: 16]  = mem[i][rd[i]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (flush) rd[i] <= wr[i];
      else if (bus.ch_yumi_o[i]) rd[i] <= rd[i] + 1;
    end
  end

  // Monitor: scoreboard compare, token model, dequeue legality
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 4; i++) dq_cnt[i] = 0;
        exp_tok = 4'b0000;
        sb.delete();
      end else begin
        logic [3:0] nt;
        nt = 4'b0000;
        check_eq("token", token, exp_tok);
        check_eq("yumi_eligible", bus.ch_yumi_o & ~(bus.ch_valid_i & ~ch_mask), 0);
        check_eq("yumi_onehot", $onehot0(bus.ch_yumi_o), 1);
        if (bus.core_valid_o) begin
          int depth;
          depth = sb.size();
          check_eq("sb_depth", depth > 0, 1);
          if (depth > 0) begin
            check_eq("core_data", bus.core_data_o, sb[0].data);
            check_eq("core_ch", bus.core_ch_o, sb[0].ch);
            if (bus.core_yumi_i) begin
              void'(sb.pop_front());
              acc_cnt++;
            end
          end
        end
        for (int i = 0; i < 4; i++) begin
          nt[i] = bus.ch_yumi_o[i] && (dq_cnt[i] == 3);
          if (bus.ch_yumi_o[i]) dq_cnt[i] = (dq_cnt[i] + 1) % 4;
          if (token[i]) tok_cnt[i]++;
        end
        exp_tok = nt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int ch, input logic [15:0] d);
    mem[ch][wr[ch]] = d;
    wr[ch]++;
  endtask

  task automatic expect_word(input int ch, input logic [15:0] d);
    exp_t e;
    e.ch   = 2'(ch);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    step();
    rst             = 1'b1;
    enable          = 1'b0;
    ch_mask         = 4'b0000;
    bus.core_yumi_i = 1'b0;
    flush           = 1'b1;
    step();
    flush = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      wait_neg();
      n++;
    end
    check_eq(tag, sb.size(), 0);
  endtask

  initial begin
    int a0;
    int t0 [4];
    bus.core_yumi_i = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 64; j++) mem[i][j] = 16'h0000;

    // Reset state and busy
    do_reset();
    wait_neg();
    check_eq("rst_valid", bus.core_valid_o, 0);
    check_eq("rst_data", bus.core_data_o, 0);
    check_eq("rst_ch", bus.core_ch_o, 0);
    check_eq("rst_token", token, 0);
    check_eq("rst_yumi", bus.ch_yumi_o, 0);
    check_eq("rst_busy", busy, 0);
    step();
    load(2, 16'h2222);
    wait_neg();
    check_eq("busy_unmasked", busy, 1);
    check_eq("yumi_disabled", bus.ch_yumi_o, 0);
    step();
    ch_mask = 4'b0100;
    wait_neg();
    check_eq("busy_masked", busy, 0);

    // Single channel, streaming
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      load(0, 16'(k));
      expect_word(0, 16'(k));
    end
    bus.core_yumi_i = 1'b1;
    a0 = acc_cnt;
    t0[0] = tok_cnt[0];
    step();
    enable = 1'b1;
    wait_neg();
    check_eq("lat_yumi", bus.ch_yumi_o, 4'b0001);
    check_eq("lat_valid_pre", bus.core_valid_o, 0);
    wait_neg();
    check_eq("lat_valid", bus.core_valid_o, 1);
    check_eq("lat_data", bus.core_data_o, 16'h0001);
    repeat (7) wait_neg();
    check_eq("single_words", acc_cnt - a0, 8);
    check_eq("single_tokens", tok_cnt[0] - t0[0], 2);

    // Round-robin fairness, all channels
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        load(c, 16'(16'hA000 | (c << 8) | k));
        expect_word(c, 16'(16'hA000 | (c << 8) | k));
      end
    bus.core_yumi_i = 1'b1;
    a0 = acc_cnt;
    for (int c = 0; c < 4; c++) t0[c] = tok_cnt[c];
    step();
    enable = 1'b1;
    repeat (17) wait_neg();
    check_eq("rr_words", acc_cnt - a0, 16);
    for (int c = 0; c < 4; c++) check_eq("rr_tokens", tok_cnt[c] - t0[c], 1);

    // Backpressure
    do_reset();
    load(1, 16'hBEEF);
    load(1, 16'h1234);
    expect_word(1, 16'hBEEF);
    expect_word(1, 16'h1234);
    step();
    enable = 1'b1;
    wait_neg();
    check_eq("bp_first_yumi", bus.ch_yumi_o, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      wait_neg();
      check_eq("bp_data", bus.core_data_o, 16'hBEEF);
      check_eq("bp_valid", bus.core_valid_o, 1);
      check_eq("bp_yumi", bus.ch_yumi_o, 0);
    end
    step();
    bus.core_yumi_i = 1'b1;
    wait_neg();
    check_eq("bp_regrant", bus.ch_yumi_o, 4'b0010);
    wait_neg();
    check_eq("bp_next", bus.core_data_o, 16'h1234);
    wait_drain("bp_drain", 5);

    // Mask, then enable low drain
    do_reset();
    ch_mask = 4'b0010;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        load(c, 16'(16'hB000 | (c << 8) | k));
        if (c != 1) expect_word(c, 16'(16'hB000 | (c << 8) | k));
      end
    bus.core_yumi_i = 1'b1;
    a0 = acc_cnt;
    step();
    enable = 1'b1;
    repeat (7) wait_neg();
    check_eq("mask_words", acc_cnt - a0, 6);
    check_eq("mask_ch1_left", wr[1] - rd[1], 2);
    step();
    ch_mask = 4'b0000;
    bus.core_yumi_i = 1'b0;
    expect_word(1, 16'hB100);
    wait_neg();
    check_eq("unmask_grant", bus.ch_yumi_o, 4'b0010);
    step();
    enable = 1'b0;
    bus.core_yumi_i = 1'b1;
    wait_neg();
    check_eq("en_drain_valid", bus.core_valid_o, 1);
    check_eq("en_drain_yumi", bus.ch_yumi_o, 0);
    wait_neg();
    check_eq("en_empty", bus.core_valid_o, 0);
    check_eq("en_empty_yumi", bus.ch_yumi_o, 0);
    check_eq("en_ch1_left", wr[1] - rd[1], 1);

    // Wrap from rr_ptr=3
    do_reset();
    load(2, 16'hC200);
    expect_word(2, 16'hC200);
    bus.core_yumi_i = 1'b1;
    step();
    enable = 1'b1;
    wait_neg();
    check_eq("wrap_setup", bus.ch_yumi_o, 4'b0100);
    step();
    enable = 1'b0;
    load(3, 16'hC300);
    load(0, 16'hC000);
    expect_word(3, 16'hC300);
    expect_word(0, 16'hC000);
    wait_neg();
    step();
    enable = 1'b1;
    wait_neg();
    check_eq("wrap_g3", bus.ch_yumi_o, 4'b1000);
    wait_neg();
    check_eq("wrap_g0", bus.ch_yumi_o, 4'b0001);
    step();
    load(0, 16'hC001);
    load(1, 16'hC101);
    expect_word(1, 16'hC101);
    expect_word(0, 16'hC001);
    wait_neg();
    check_eq("wrap_ptr1", bus.ch_yumi_o, 4'b0010);
    wait_neg();
    check_eq("wrap_then0", bus.ch_yumi_o, 4'b0001);
    wait_drain("wrap_drain", 5);

    // Reset while FULL with ch1 count at 3
    do_reset();
    load(1, 16'hD000);
    load(1, 16'hD001);
    load(1, 16'hD002);
    expect_word(1, 16'hD000);
    expect_word(1, 16'hD001);
    expect_word(1, 16'hD002);
    bus.core_yumi_i = 1'b1;
    step();
    enable = 1'b1;
    repeat (3) wait_neg();
    step();
    bus.core_yumi_i = 1'b0;
    wait_neg();
    check_eq("pre_rst_full", bus.core_valid_o, 1);
    check_eq("pre_rst_data", bus.core_data_o, 16'hD002);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_neg();
    check_eq("mid_rst_valid", bus.core_valid_o, 0);
    check_eq("mid_rst_data", bus.core_data_o, 0);
    check_eq("mid_rst_ch", bus.core_ch_o, 0);
    check_eq("mid_rst_token", token, 0);
    check_eq("mid_rst_yumi", bus.ch_yumi_o, 0);
    t0[1] = tok_cnt[1];
    step();
    load(1, 16'hD003);
    expect_word(1, 16'hD003);
    bus.core_yumi_i = 1'b1;
    wait_neg();
    check_eq("post_rst_yumi", bus.ch_yumi_o, 4'b0010);
    repeat (2) wait_neg();
    check_eq("post_rst_no_token", tok_cnt[1] - t0[1], 0);
    wait_drain("post_rst_drain", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bsg_down_ch_sched.md
# bsg_down_ch_sched

Round-robin scheduler that drains the per-channel downstream buffers into the single core-side output port. It sits between the `NUM_CH` downstream channel FIFOs (read side, core clock domain) and the core interface. It grants one channel per cycle, registers the selected word, and returns credit tokens to the I/O side at a fixed decimation.

## Interface

Parameters:
- `NUM_CH`, 4: number of downstream channels; must be ≥ 2.
- `DW`, 16: channel word width.
- `TOK_DEC`, 4: words drained per returned token; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable_i`  in  1  permits new grants when high.
- `ch_mask_i`  in  NUM_CH  bit i high excludes channel i from arbitration.
- `ch_valid_i`  in  NUM_CH  channel i FIFO non-empty.
- `ch_data_i`  in  NUM_CH*DW  channel i head word at bits [i*DW +: DW].
- `ch_yumi_o`  out  NUM_CH  one-hot dequeue pulse to channel FIFO.
- `core_valid_o`  out  1  output register holds a word.
- `core_data_o`  out  DW  held word.
- `core_ch_o`  out  clog2(NUM_CH)  source channel of held word.
- `core_yumi_i`  in  1  core consumes held word this cycle.
- `token_o`  out  NUM_CH  one-cycle credit pulse per channel.
- `busy_o`  out  1  `core_valid_o` OR any `ch_valid_i` unmasked.

## Operation

- Output register states:
  - EMPTY: `core_valid_o`=0.
  - FULL: `core_valid_o`=1.
- `slot_free` = EMPTY OR (FULL AND `core_yumi_i`).
- Grant condition: `slot_free` AND `enable_i` AND at least one eligible channel. A channel is eligible when `ch_valid_i[i]` AND NOT `ch_mask_i[i]`.
- Selection: the first eligible channel scanning upward from `rr_ptr`, wrapping modulo NUM_CH.
- On grant g:
  - `ch_yumi_o[g]`=1 in the same cycle (combinational).
  - Next cycle: `core_data_o` ← `ch_data_i[g]`, `core_ch_o` ← g, state FULL.
  - `rr_ptr` ← (g+1) mod NUM_CH.
- FULL with `core_yumi_i` and no grant → EMPTY. FULL without `core_yumi_i` → hold; data and channel stay stable.
- `rr_ptr` is unchanged when there is no grant.
- Token counters:
  - One counter per channel, width log2(TOK_DEC). It increments on each `ch_yumi_o[i]`.
  - When the counter equals TOK_DEC−1 at a yumi, it wraps to 0 and `token_o[i]`=1 on the next cycle only.
- `enable_i` low: no grants. A held word is still presented and may be consumed. Counters are unaffected.
- `ch_mask_i` changes affect only grants evaluated in that cycle; a held word is never revoked.
- `core_yumi_i` while EMPTY is ignored (protocol violation; no state change).
- `ch_valid_i[i]` low for a masked or unselected channel has no effect.

## Timing

- Reset values:
  - `core_valid_o`=0, `core_data_o`=0, `core_ch_o`=0.
  - `token_o`=0, `ch_yumi_o`=0, `busy_o` follows its inputs.
  - `rr_ptr`=0, all token counters=0.
- Reset mid-operation: the held word is discarded, partial token counts are lost, and no token pulse is emitted in the cycle after reset.
- Latency: `ch_valid_i` high at cycle t with the slot free → `ch_yumi_o` at t, `core_valid_o` at t+1.
- Throughput: 1 word/cycle when `core_yumi_i` is held high and eligible data is present (pass-through on simultaneous yumi+grant).
- `token_o` latency: 1 cycle after the TOK_DEC-th dequeue of that channel.
- `ch_yumi_o` is at most one-hot and never asserted for an ineligible channel.

## Test plan

- Single channel:
  - Stimulus: ch0 valid continuously with data 0x0001..0x0008, `core_yumi_i`=1.
  - Required: words emerge in order, one per cycle from t+1, `core_ch_o`=0; `token_o[0]` pulses after the 4th and 8th dequeue.
- Round-robin fairness:
  - Stimulus: all 4 channels valid continuously, yumi=1.
  - Required: `core_ch_o` sequence 0,1,2,3,0,1…; each channel gets exactly one token per 16 cycles.
- Backpressure:
  - Stimulus: word 0xBEEF held with yumi=0 for 5 cycles.
  - Required: `core_data_o`=0xBEEF stable, `ch_yumi_o`=0 throughout. On yumi=1 the next word is granted in the same cycle.
- Mask/enable:
  - Stimulus: `ch_mask_i`=4'b0010 with all channels valid.
  - Required: sequence 0,2,3,0,…; with `enable_i`=0 a held word drains and then `core_valid_o`=0 with no yumis.
- Wrap:
  - Stimulus: only ch3 and ch0 valid, `rr_ptr`=3.
  - Required: grant 3 then 0; `rr_ptr` returns to 1.
- Reset mid-operation:
  - Stimulus: `rst` asserted while FULL with ch1 count=3.
  - Required: next cycle all outputs 0; a later single ch1 dequeue produces no token.
